// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed 1..8 digit common-anode seven-segment scanner
//
// Scans NUM_DIGITS digits at SCAN_HZ slots per second. Each slot has 16 PWM sub-phases
// for brightness. New display data is staged on load. It is committed to the shadow
// registers only at a frame boundary, so the display never tears.
//
// Optional feature: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
//
// Ports:
//   CLK100MHZ    in   system clock
//   reset        in   synchronous active-high reset
//   value        in   packed hex nibbles; nibble i drives digit i (digit 0 = AN[0])
//   dp_mask      in   1 = decimal point lit on digit i
//   digit_en     in   1 = digit i displayed
//   brightness   in   duty level, 0 = 1/16 on, 15 = full on (sampled live)
//   load         in   strobe that stages value/dp_mask/digit_en
//   load_ack     out  pulse when staged data is committed
//   frame_start  out  pulse after the scan index wraps to 0
//   AN           out  anodes, active low
//   SEG          out  {CA,CB,CC,CD,CE,CF,CG,DP}, active low
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                    CLK100MHZ,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [7:0]              AN,
    output logic [7:0]              SEG
);
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int SUB_LEN = DIV / 16;
    localparam int PW      = $clog2(DIV);
    localparam int SW      = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;

    logic [PW-1:0]           presc_q;
    logic [SW-1:0]           sub_cnt_q;
    logic [3:0]              sub_idx_q;
    logic [2:0]              idx_q;
    logic                    pending_q;
    logic [4*NUM_DIGITS-1:0] stg_val_q, sh_val_q;
    logic [NUM_DIGITS-1:0]   stg_dp_q, sh_dp_q;
    logic [NUM_DIGITS-1:0]   stg_en_q, sh_en_q;
    logic                    load_ack_q, frame_start_q;
    logic [7:0]              an_q, seg_q;

    logic                    slot_tick, sub_end, wrap, commit;
    logic [3:0]              nib;
    logic                    en_bit, dp_bit, lit;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_found;
    logic [7:0]              an_d, seg_d;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] r;
        case (h)
            4'h0: r = 7'b0000001;
            4'h1: r = 7'b1001111;
            4'h2: r = 7'b0010010;
            4'h3: r = 7'b0000110;
            4'h4: r = 7'b1001100;
            4'h5: r = 7'b0100100;
            4'h6: r = 7'b0100000;
            4'h7: r = 7'b0001111;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0000100;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b1100000;
            4'hC: r = 7'b0110001;
            4'hD: r = 7'b1000010;
            4'hE: r = 7'b0110000;
            default: r = 7'b0111000;
        endcase
        return r;
    endfunction

    assign slot_tick = (presc_q == PW'(DIV - 1));
    assign sub_end   = (sub_cnt_q == SW'(SUB_LEN - 1));
    assign wrap      = slot_tick && (idx_q == 3'(NUM_DIGITS - 1));
    // A load landing on the wrap tick is committed directly, even with nothing pending.
    assign commit    = wrap && (pending_q || load);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; zeros seen before any enabled nonzero digit are leading.
    always_comb begin
        lz_mask  = '0;
        lz_found = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (sh_en_q[i] && (sh_val_q[i*4 +: 4] != 4'h0)) begin
                lz_found = 1'b1;
            end
            lz_mask[i] = sh_en_q[i] && (sh_val_q[i*4 +: 4] == 4'h0) && !lz_found;
        end
    end
`else
    assign lz_mask  = '0;
    assign lz_found = 1'b0;
`endif

    always_comb begin
        nib    = 4'h0;
        en_bit = 1'b0;
        dp_bit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                nib    = sh_val_q[i*4 +: 4];
                en_bit = sh_en_q[i] && !lz_mask[i];
                dp_bit = sh_dp_q[i];
            end
        end
        lit   = en_bit && (sub_idx_q <= brightness);
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = {hex7(nib), ~dp_bit};
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            presc_q       <= '0;
            sub_cnt_q     <= '0;
            sub_idx_q     <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            stg_val_q     <= '0;
            stg_dp_q      <= '0;
            stg_en_q      <= '0;
            sh_val_q      <= '0;
            sh_dp_q       <= '0;
            sh_en_q       <= '0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            an_q          <= 8'hFF;
            seg_q         <= 8'hFF;
        end else begin
            presc_q   <= slot_tick ? '0 : presc_q + PW'(1);
            sub_cnt_q <= (slot_tick || sub_end) ? '0 : sub_cnt_q + SW'(1);
            if (slot_tick) begin
                sub_idx_q <= 4'd0;
                idx_q     <= wrap ? 3'd0 : idx_q + 3'd1;
            end else if (sub_end) begin
                sub_idx_q <= sub_idx_q + 4'd1;
            end
            if (load) begin
                stg_val_q <= value;
                stg_dp_q  <= dp_mask;
                stg_en_q  <= digit_en;
            end
            if (commit) begin
                pending_q <= 1'b0;
                sh_val_q  <= load ? value    : stg_val_q;
                sh_dp_q   <= load ? dp_mask  : stg_dp_q;
                sh_en_q   <= load ? digit_en : stg_en_q;
            end else if (load) begin
                pending_q <= 1'b1;
            end
            load_ack_q    <= commit;
            frame_start_q <= wrap;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign AN          = an_q;
    assign SEG         = seg_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - scoreboard bench for seven_seg_scanner (4 digits, 16-cycle slots)
module tb_seven_seg_scanner;
    localparam int ND = 4;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  en;
    } frame_t;

    localparam logic [6:0] TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  brightness = 4'd15;
    logic        load = 1'b0;
    logic        load_ack, frame_start;
    logic [7:0]  AN, SEG;

    frame_t exp_q[$];
    frame_t sh;
    int     n;
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(.NUM_DIGITS(ND), .CLK_HZ(1600), .SCAN_HZ(100)) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .value      (value),
        .dp_mask    (dp_mask),
        .digit_en   (digit_en),
        .brightness (brightness),
        .load       (load),
        .load_ack   (load_ack),
        .frame_start(frame_start),
        .AN         (AN),
        .SEG        (SEG)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    function automatic bit lz_blank(input frame_t f, input int d);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        bit found = 0;
        for (int i = ND - 1; i > d; i--)
            if (f.en[i] && f.v[i*4 +: 4] != 4'h0) found = 1;
        return (d != 0) && f.en[d] && (f.v[d*4 +: 4] == 4'h0) && !found;
`else
        return 0;
`endif
    endfunction

    // n counts clock edges since reset was released; outputs after edge n reflect slot state n-1.
    task automatic check_cycle();
        logic [7:0] ean, eseg;
        logic       eack, efs, lit;
        logic [3:0] nib;
        int         s, d;
        ean = 8'hFF; eseg = 8'hFF; eack = 1'b0; efs = 1'b0;
        if (n >= 1) begin
            s   = n - 1;
            d   = (s / 16) % ND;
            nib = sh.v[d*4 +: 4];
            lit = sh.en[d] && ((s % 16) <= int'(brightness)) && !lz_blank(sh, d);
            if (lit) begin
                ean[d] = 1'b0;
                eseg   = {TBL[nib], ~sh.dp[d]};
            end
            efs  = (n % 64 == 0);
            eack = efs && (exp_q.size() > 0);
        end
        check_eq("AN", AN, ean);
        check_eq("SEG", SEG, eseg);
        check_eq("frame_start", frame_start, efs);
        check_eq("load_ack", load_ack, eack);
        if (eack) sh = exp_q.pop_front();
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            n = 0;
            exp_q.delete();
            sh = '0;
        end else begin
            n++;
        end
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run(input int k);
        repeat (k) cycle();
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < 64 && (n % 64) != phase; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
        frame_t f;
        f.v = v; f.dp = dp; f.en = en;
        value = v; dp_mask = dp; digit_en = en; load = 1'b1;
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = f;
        else exp_q.push_back(f);
        cycle();
        load = 1'b0;
    endtask

    initial begin
        n  = 0;
        sh = '0;
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(200);

        do_load(16'h4321, 4'h0, 4'hF);
        run(140);

        brightness = 4'd3;
        run(64);
        brightness = 4'd15;

        align(5);
        do_load(16'h1111, 4'h0, 4'hF);
        run(10);
        do_load(16'h2222, 4'h0, 4'hF);
        run(140);

        align(63);
        do_load(16'hABCD, 4'b0010, 4'hF);
        run(80);

        do_load(16'h8765, 4'b0100, 4'b1011);
        run(140);

        align(10);
        do_load(16'h9999, 4'hF, 4'hF);
        run(5);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(200);

        do_load(16'h0050, 4'b0001, 4'hF);
        run(140);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
